// File: rtl/console_writer.sv
// Character-stream front end for the VGA console: turns a byte stream into
// char_array write commands while tracking a wrapping text cursor.
module console_writer #(
  parameter int unsigned WIDTH         = 80,
  parameter int unsigned HEIGHT        = 45,
  parameter logic [11:0] DEFAULT_COLOR = 12'hFFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_char,
  input  logic [11:0] in_color,
  output logic        w_en,
  output logic [7:0]  w_pos_x,
  output logic [7:0]  w_pos_y,
  output logic [7:0]  w_char,
  output logic [11:0] w_color,
  output logic [7:0]  cursor_x,
  output logic [7:0]  cursor_y,
  output logic        busy
);

  localparam int unsigned POS_W   = 8;
  localparam int unsigned CHAR_W  = 8;
  localparam int unsigned COLOR_W = 12;

  localparam logic [POS_W-1:0]  X_MAX    = POS_W'(WIDTH - 1);
  localparam logic [POS_W-1:0]  Y_MAX    = POS_W'(HEIGHT - 1);
  localparam logic [CHAR_W-1:0] CH_BS    = 8'h08;
  localparam logic [CHAR_W-1:0] CH_LF    = 8'h0A;
  localparam logic [CHAR_W-1:0] CH_FF    = 8'h0C;
  localparam logic [CHAR_W-1:0] CH_CR    = 8'h0D;
  localparam logic [CHAR_W-1:0] CH_SPACE = 8'h20;
  localparam logic [CHAR_W-1:0] CH_DEL   = 8'h7F;

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t              r_state, w_state_nx;
  logic [POS_W-1:0]    r_cur_x, r_cur_y, w_cur_x_nx, w_cur_y_nx;
  logic [POS_W-1:0]    r_clr_x, r_clr_y, w_clr_x_nx, w_clr_y_nx;
  logic [COLOR_W-1:0]  r_clr_color, w_clr_color_nx;
  logic                r_w_en, w_wen_nx;
  logic [POS_W-1:0]    r_w_x, r_w_y, w_wx_nx, w_wy_nx;
  logic [CHAR_W-1:0]   r_w_char, w_wchar_nx;
  logic [COLOR_W-1:0]  r_w_color, w_wcolor_nx;
  logic                r_in_ready, r_busy, w_ready_nx, w_busy_nx;

  logic                w_accept, w_printable, w_clr_last, w_bs_ok;
  logic [POS_W-1:0]    w_y_adv, w_bs_x, w_bs_y;

  // Shared decode of the incoming byte and cursor neighbourhood
  assign w_accept    = in_valid && (r_state == ST_IDLE);
  assign w_printable = (in_char >= CH_SPACE) && (in_char != CH_DEL);
  assign w_y_adv     = (r_cur_y == Y_MAX) ? POS_W'(0) : r_cur_y + POS_W'(1);
  assign w_bs_ok     = (r_cur_x != POS_W'(0)) || (r_cur_y != POS_W'(0));
  assign w_bs_x      = (r_cur_x != POS_W'(0)) ? r_cur_x - POS_W'(1) : X_MAX;
  assign w_bs_y      = (r_cur_x != POS_W'(0)) ? r_cur_y : r_cur_y - POS_W'(1);
  assign w_clr_last  = (r_clr_x == X_MAX) && (r_clr_y == Y_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_CLEAR;
      r_cur_x     <= '0;
      r_cur_y     <= '0;
      r_clr_x     <= '0;
      r_clr_y     <= '0;
      r_clr_color <= DEFAULT_COLOR;
      r_w_en      <= 1'b0;
      r_w_x       <= '0;
      r_w_y       <= '0;
      r_w_char    <= '0;
      r_w_color   <= '0;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b1;
    end else begin
      r_state     <= w_state_nx;
      r_cur_x     <= w_cur_x_nx;
      r_cur_y     <= w_cur_y_nx;
      r_clr_x     <= w_clr_x_nx;
      r_clr_y     <= w_clr_y_nx;
      r_clr_color <= w_clr_color_nx;
      r_w_en      <= w_wen_nx;
      r_w_x       <= w_wx_nx;
      r_w_y       <= w_wy_nx;
      r_w_char    <= w_wchar_nx;
      r_w_color   <= w_wcolor_nx;
      r_in_ready  <= w_ready_nx;
      r_busy      <= w_busy_nx;
    end
  end

  // Next state: FSM, cursor movement and clear sweep counter
  always_comb begin
    w_state_nx     = r_state;
    w_cur_x_nx     = r_cur_x;
    w_cur_y_nx     = r_cur_y;
    w_clr_x_nx     = r_clr_x;
    w_clr_y_nx     = r_clr_y;
    w_clr_color_nx = r_clr_color;
    case (r_state)
      ST_CLEAR: begin
        if (w_clr_last) begin
          w_clr_x_nx = '0;
          w_clr_y_nx = '0;
          w_state_nx = ST_IDLE;
        end else if (r_clr_x == X_MAX) begin
          w_clr_x_nx = '0;
          w_clr_y_nx = r_clr_y + POS_W'(1);
        end else begin
          w_clr_x_nx = r_clr_x + POS_W'(1);
        end
      end
      ST_IDLE: begin
        if (w_accept) begin
          if (w_printable) begin
            if (r_cur_x == X_MAX) begin
              w_cur_x_nx = '0;
              w_cur_y_nx = w_y_adv;
            end else begin
              w_cur_x_nx = r_cur_x + POS_W'(1);
            end
          end else begin
            case (in_char)
              CH_LF: begin
                w_cur_x_nx = '0;
                w_cur_y_nx = w_y_adv;
              end
              CH_CR: w_cur_x_nx = '0;
              CH_BS: begin
                if (w_bs_ok) begin
                  w_cur_x_nx = w_bs_x;
                  w_cur_y_nx = w_bs_y;
                end
              end
              CH_FF: begin
                w_clr_color_nx = in_color;
                w_cur_x_nx     = '0;
                w_cur_y_nx     = '0;
                w_clr_x_nx     = '0;
                w_clr_y_nx     = '0;
                w_state_nx     = ST_CLEAR;
              end
              default: ;
            endcase
          end
        end
      end
      default: w_state_nx = ST_CLEAR;
    endcase
  end

  // Output: write command for the next cycle plus handshake status
  always_comb begin
    w_wen_nx    = 1'b0;
    w_wx_nx     = r_w_x;
    w_wy_nx     = r_w_y;
    w_wchar_nx  = r_w_char;
    w_wcolor_nx = r_w_color;
    w_ready_nx  = (w_state_nx == ST_IDLE);
    w_busy_nx   = (w_state_nx != ST_IDLE);
    if (r_state == ST_CLEAR) begin
      w_wen_nx    = 1'b1;
      w_wx_nx     = r_clr_x;
      w_wy_nx     = r_clr_y;
      w_wchar_nx  = CH_SPACE;
      w_wcolor_nx = r_clr_color;
    end else if (w_accept && w_printable) begin
      w_wen_nx    = 1'b1;
      w_wx_nx     = r_cur_x;
      w_wy_nx     = r_cur_y;
      w_wchar_nx  = in_char;
      w_wcolor_nx = in_color;
    end else if (w_accept && (in_char == CH_BS) && w_bs_ok) begin
      w_wen_nx    = 1'b1;
      w_wx_nx     = w_bs_x;
      w_wy_nx     = w_bs_y;
      w_wchar_nx  = CH_SPACE;
      w_wcolor_nx = in_color;
    end
  end

  assign in_ready = r_in_ready;
  assign busy     = r_busy;
  assign w_en     = r_w_en;
  assign w_pos_x  = r_w_x;
  assign w_pos_y  = r_w_y;
  assign w_char   = r_w_char;
  assign w_color  = r_w_color;
  assign cursor_x = r_cur_x;
  assign cursor_y = r_cur_y;

endmodule

// File: tb/tb_console_writer.sv
// Scoreboard bench for console_writer: expected writes are queued as bytes are
// driven and compared against the write port as each write appears.
module tb_console_writer;

  localparam int unsigned W     = 80;
  localparam int unsigned H     = 45;
  localparam int unsigned NCELL = W * H;

  typedef struct packed {
    logic [7:0]  x;
    logic [7:0]  y;
    logic [7:0]  ch;
    logic [11:0] col;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_char = 8'h00;
  logic [11:0] in_color = 12'h000;
  logic        w_en;
  logic [7:0]  w_pos_x, w_pos_y, w_char;
  logic [11:0] w_color;
  logic [7:0]  cursor_x, cursor_y;
  logic        busy;

  wr_t exp_q[$];
  wr_t mon_e;
  int  checks = 0;
  int  errors = 0;
  logic [7:0] mx = 8'd0;
  logic [7:0] my = 8'd0;

  console_writer #(.WIDTH(W), .HEIGHT(H), .DEFAULT_COLOR(12'hFFF)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_char(in_char), .in_color(in_color), .w_en(w_en), .w_pos_x(w_pos_x),
    .w_pos_y(w_pos_y), .w_char(w_char), .w_color(w_color),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Pop one expectation for every write the DUT presents
  always @(negedge clk) begin
    if (reset_n === 1'b1 && w_en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got x=%0d y=%0d ch=%h col=%h required no write",
                 w_pos_x, w_pos_y, w_char, w_color);
      end else begin
        mon_e = exp_q.pop_front();
        if ({w_pos_x, w_pos_y, w_char, w_color} !== mon_e) begin
          errors++;
          $display("FAIL write got x=%0d y=%0d ch=%h col=%h required x=%0d y=%0d ch=%h col=%h",
                   w_pos_x, w_pos_y, w_char, w_color, mon_e.x, mon_e.y, mon_e.ch, mon_e.col);
        end
      end
    end
  end

  task automatic push_wr(input logic [7:0] x, input logic [7:0] y,
                         input logic [7:0] ch, input logic [11:0] col);
    wr_t e;
    e.x = x; e.y = y; e.ch = ch; e.col = col;
    exp_q.push_back(e);
  endtask

  task automatic push_clear(input logic [11:0] col);
    for (int y = 0; y < int'(H); y++)
      for (int x = 0; x < int'(W); x++)
        push_wr(8'(x), 8'(y), 8'h20, col);
  endtask

  task automatic model_adv_y();
    my = (my == 8'(H - 1)) ? 8'd0 : my + 8'd1;
  endtask

  // Reference behaviour of one accepted byte
  task automatic model(input logic [7:0] c, input logic [11:0] col);
    if (c >= 8'h20 && c != 8'h7F) begin
      push_wr(mx, my, c, col);
      if (mx == 8'(W - 1)) begin mx = 8'd0; model_adv_y(); end
      else mx = mx + 8'd1;
    end else if (c == 8'h0A) begin
      mx = 8'd0; model_adv_y();
    end else if (c == 8'h0D) begin
      mx = 8'd0;
    end else if (c == 8'h08) begin
      if (mx != 8'd0) begin mx = mx - 8'd1; push_wr(mx, my, 8'h20, col); end
      else if (my != 8'd0) begin mx = 8'(W - 1); my = my - 8'd1; push_wr(mx, my, 8'h20, col); end
    end else if (c == 8'h0C) begin
      mx = 8'd0; my = 8'd0; push_clear(col);
    end
  endtask

  // Hold a byte valid until accepted; returns 1 ns after the accepting edge
  task automatic send_byte(input logic [7:0] c, input logic [11:0] col);
    int n = 0;
    in_char = c; in_color = col; in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 6000) begin @(posedge clk); #1; n++; end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready_timeout char=%h in_ready=%b required 1", c, in_ready);
      in_valid = 1'b0;
      return;
    end
    model(c, col);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end
    while ((exp_q.size() != 0 || in_ready !== 1'b1) && n < 6000);
    checks++;
    if (exp_q.size() != 0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_drain pending=%0d in_ready=%b required pending=0 in_ready=1",
               name, exp_q.size(), in_ready);
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  // Release reset and expect one full power-up clear with in_ready on the last write
  task automatic release_and_clear(input string name);
    int n = 0, hi = 0;
    push_clear(12'hFFF);
    mx = 8'd0; my = 8'd0;
    reset_n = 1'b1;
    do begin
      @(posedge clk); #1; n++;
      if (w_en === 1'b1) hi++;
    end while (in_ready !== 1'b1 && n < 5000);
    checks++;
    if (n != int'(NCELL) || hi != int'(NCELL)) begin
      errors++;
      $display("FAIL %s_clear_len edges=%0d wen_edges=%0d required %0d", name, n, hi, NCELL);
    end
    checks++;
    if (w_en !== 1'b1 || w_pos_x !== 8'd79 || w_pos_y !== 8'd44 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_ready_edge got w_en=%b pos=(%0d,%0d) busy=%b required 1 (79,44) 0",
               name, w_en, w_pos_x, w_pos_y, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (w_en !== 1'b0) begin
      errors++;
      $display("FAIL %s_clear_end got w_en=%b required 0", name, w_en);
    end
    wait_idle(name);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({w_en, w_pos_x, w_pos_y, w_char, w_color, cursor_x, cursor_y, in_ready, busy} !==
        {1'b0, 8'd0, 8'd0, 8'd0, 12'd0, 8'd0, 8'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_values got w_en=%b pos=(%0d,%0d) ch=%h col=%h cur=(%0d,%0d) rdy=%b busy=%b required zeros busy=1",
               w_en, w_pos_x, w_pos_y, w_char, w_color, cursor_x, cursor_y, in_ready, busy);
    end
    release_and_clear("powerup");
  endtask

  task automatic test_stream();
    send_byte("A", 12'h0F0);
    send_byte("B", 12'h0F0);
    wait_idle("ab");
    checks++;
    if (cursor_x !== 8'd2 || cursor_y !== 8'd0) begin
      errors++;
      $display("FAIL ab_cursor got (%0d,%0d) required (2,0)", cursor_x, cursor_y);
    end
  endtask

  task automatic test_wrap();
    send_byte(8'h0D, 12'h000);
    repeat (44) send_byte(8'h0A, 12'h000);
    repeat (79) send_byte("x", 12'h123);
    checks++;
    if (cursor_x !== 8'd79 || cursor_y !== 8'd44) begin
      errors++;
      $display("FAIL pre_wrap_cursor got (%0d,%0d) required (79,44)", cursor_x, cursor_y);
    end
    send_byte("Z", 12'h456);
    wait_idle("wrap_z");
    checks++;
    if (cursor_x !== 8'd0 || cursor_y !== 8'd0) begin
      errors++;
      $display("FAIL wrap_z_cursor got (%0d,%0d) required (0,0)", cursor_x, cursor_y);
    end
    repeat (44) send_byte(8'h0A, 12'h000);
    send_byte(8'h0A, 12'h000);
    wait_idle("lf_wrap");
    checks++;
    if (cursor_x !== 8'd0 || cursor_y !== 8'd0) begin
      errors++;
      $display("FAIL lf_wrap_cursor got (%0d,%0d) required (0,0)", cursor_x, cursor_y);
    end
  endtask

  task automatic test_backspace();
    send_byte(8'h08, 12'h111);
    wait_idle("bs_origin");
    checks++;
    if (cursor_x !== 8'd0 || cursor_y !== 8'd0) begin
      errors++;
      $display("FAIL bs_origin_cursor got (%0d,%0d) required (0,0)", cursor_x, cursor_y);
    end
    repeat (3) send_byte(8'h0A, 12'h000);
    send_byte(8'h08, 12'h222);
    wait_idle("bs_row");
    checks++;
    if (cursor_x !== 8'd79 || cursor_y !== 8'd2) begin
      errors++;
      $display("FAIL bs_row_cursor got (%0d,%0d) required (79,2)", cursor_x, cursor_y);
    end
    send_byte(8'h0D, 12'h000);
    repeat (43) send_byte(8'h0A, 12'h000);
    repeat (5) send_byte("y", 12'h333);
    send_byte(8'h08, 12'h444);
    wait_idle("bs_mid");
    checks++;
    if (cursor_x !== 8'd4 || cursor_y !== 8'd0) begin
      errors++;
      $display("FAIL bs_mid_cursor got (%0d,%0d) required (4,0)", cursor_x, cursor_y);
    end
  endtask

  task automatic test_ignored();
    logic [7:0] codes [3];
    codes[0] = 8'h00; codes[1] = 8'h7F; codes[2] = 8'h1B;
    for (int i = 0; i < 3; i++) begin
      send_byte(codes[i], 12'hABC);
      checks++;
      if (in_ready !== 1'b1 || cursor_x !== 8'd4 || cursor_y !== 8'd0) begin
        errors++;
        $display("FAIL ignored_%h got rdy=%b cur=(%0d,%0d) required rdy=1 cur=(4,0)",
                 codes[i], in_ready, cursor_x, cursor_y);
      end
    end
    wait_idle("ignored");
  endtask

  task automatic test_ff_hold();
    send_byte(8'h0C, 12'h00F);
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL ff_status got rdy=%b busy=%b required rdy=0 busy=1", in_ready, busy);
    end
    send_byte("Q", 12'h0F0);
    wait_idle("ff_q");
    checks++;
    if (cursor_x !== 8'd1 || cursor_y !== 8'd0) begin
      errors++;
      $display("FAIL ff_q_cursor got (%0d,%0d) required (1,0)", cursor_x, cursor_y);
    end
  endtask

  task automatic test_midclear_reset();
    int n = 0, hi = 0;
    reset_n = 1'b0;
    @(posedge clk); #1;
    push_clear(12'hFFF);
    reset_n = 1'b1;
    while (hi < 1000 && n < 3000) begin
      @(posedge clk); #1; n++;
      if (w_en === 1'b1) hi++;
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (w_en !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0 || hi != 1000) begin
      errors++;
      $display("FAIL midclear_reset got w_en=%b busy=%b rdy=%b writes=%0d required 0 1 0 1000",
               w_en, busy, in_ready, hi);
    end
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    release_and_clear("restart");
  endtask

  initial begin
    test_reset();
    test_stream();
    test_wrap();
    test_backspace();
    test_ignored();
    test_ff_hold();
    test_midclear_reset();
    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected got %0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
